// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types, defaults and helpers for the gray input conditioner
package gray_pkg;

  // 10 ms worth of 27 MHz clock cycles
  localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;

  // Button debounce FSM states
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Counter width: ceil(log2(cycles)), never narrower than one bit
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

  // True when a and b differ in more than one bit position.
  // d & (d - 1) clears the lowest set bit; anything left means popcount > 1.
  function automatic logic multi_bit_step(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = a ^ b;
    return (d & (d - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/debounce_counter.sv
// rtl/debounce_counter.sv - saturating stability counter shared by switch and button paths
module debounce_counter #(
  parameter int WIDTH  = 2,
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic stable_target,
  output logic commit
);

  // sample=1 means "input matched the held candidate this cycle"; the cycle in
  // which the candidate was captured already counts as the first stable cycle,
  // so commit fires while the count sits at CYCLES-2 and the owner's register
  // updates on the same edge the count reaches CYCLES-1.
  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_FIRE = WIDTH'((CYCLES >= 2) ? (CYCLES - 2) : 0);

  logic [WIDTH-1:0] count;

  // Clear on any mismatch, count up while stable, hold at the top value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!sample) begin
      count <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + WIDTH'(1);
    end
  end

  // stable_target gates commits that would not change anything downstream
  assign commit = sample && stable_target && (count >= CNT_FIRE);

endmodule

// File: rtl/gray_input_conditioner.sv
// rtl/gray_input_conditioner.sv - synchronize and debounce a Gray-code switch and a push-button
module gray_input_conditioner
  import gray_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int BTN_TOGGLE      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gray_raw,
  input  logic       btn_raw,
  output logic [3:0] gray_code,
  output logic       show_decades,
  output logic       gray_valid,
  output logic       gray_step_err
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic [3:0] gray_meta;
  logic [3:0] gray_sync;
  logic       btn_meta;
  logic       btn_sync;

  // Two-flop synchronizers on every raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_meta <= '0;
      gray_sync <= '0;
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      gray_meta <= gray_raw;
      gray_sync <= gray_meta;
      btn_meta  <= btn_raw;
      btn_sync  <= btn_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Switch path: the four bits are debounced as one group
  // ---------------------------------------------------------------------
  logic [3:0] gray_cand;
  logic       gray_match;
  logic       gray_target;
  logic       gray_commit;

  assign gray_match  = (gray_sync == gray_cand);
  assign gray_target = (gray_cand != gray_code);

  // Candidate tracks the synchronized value; a change restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_cand <= '0;
    end else if (!gray_match) begin
      gray_cand <= gray_sync;
    end
  end

  debounce_counter #(
    .WIDTH  (CNT_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_gray_cnt (
    .clk           (clk),
    .rst           (rst),
    .sample        (gray_match),
    .stable_target (gray_target),
    .commit        (gray_commit)
  );

  // Load the committed code, pulse valid, latch multi-bit steps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_code     <= '0;
      gray_valid    <= 1'b0;
      gray_step_err <= 1'b0;
    end else begin
      gray_valid <= gray_commit;
      if (gray_commit) begin
        gray_code <= gray_cand;
        if (multi_bit_step(gray_cand, gray_code)) begin
          gray_step_err <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Button path: four-state FSM, counter only runs in the two wait states
  // ---------------------------------------------------------------------
  btn_state_t btn_state;
  logic       btn_sample;
  logic       btn_target;
  logic       btn_commit;

  // Count cycles spent at the level the current wait state is confirming
  always_comb begin
    btn_sample = 1'b0;
    btn_target = 1'b0;
    case (btn_state)
      PRESS_WAIT: begin
        btn_sample = btn_sync;
        btn_target = 1'b1;
      end
      RELEASE_WAIT: begin
        btn_sample = !btn_sync;
        btn_target = 1'b1;
      end
      default: begin
        btn_sample = 1'b0;
        btn_target = 1'b0;
      end
    endcase
  end

  debounce_counter #(
    .WIDTH  (CNT_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_cnt (
    .clk           (clk),
    .rst           (rst),
    .sample        (btn_sample),
    .stable_target (btn_target),
    .commit        (btn_commit)
  );

  // Button FSM with registered show_decades (toggle or level mode)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_state    <= IDLE;
      show_decades <= 1'b0;
    end else begin
      case (btn_state)
        IDLE: begin
          if (btn_sync) begin
            btn_state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!btn_sync) begin
            btn_state <= IDLE;
          end else if (btn_commit) begin
            btn_state <= HELD;
            if (BTN_TOGGLE != 0) begin
              show_decades <= !show_decades;
            end else begin
              show_decades <= 1'b1;
            end
          end
        end
        HELD: begin
          if (!btn_sync) begin
            btn_state <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (btn_sync) begin
            btn_state <= HELD;
          end else if (btn_commit) begin
            btn_state <= IDLE;
            if (BTN_TOGGLE == 0) begin
              show_decades <= 1'b0;
            end
          end
        end
        default: begin
          btn_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gray_input_conditioner.md
GRAY_INPUT_CONDITIONER -- requirements
Module: gray_input_conditioner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, on ports named clk and rst.
REQ-002 Parameter DEBOUNCE_CYCLES SHALL default to 270000 and SHALL set the stable-input cycles required before commit (10 ms at 27 MHz).
REQ-003 Parameter BTN_TOGGLE SHALL default to 1: 1 = show_decades toggles on each press; 0 = show_decades follows the held button level.
REQ-004 Port clk SHALL be an input, 1 bit: system clock.
REQ-005 Port rst SHALL be an input, 1 bit: asynchronous active-high reset.
REQ-006 Port gray_raw SHALL be an input, 4 bits: raw switch Gray code, asynchronous, may bounce.
REQ-007 Port btn_raw SHALL be an input, 1 bit: raw push-button, active-high, asynchronous, may bounce.
REQ-008 Port gray_code SHALL be an output, 4 bits: debounced Gray code for the decoder stage.
REQ-009 Port show_decades SHALL be an output, 1 bit: debounced decade-select for the decoder stage.
REQ-010 Port gray_valid SHALL be an output, 1 bit: one-cycle pulse when gray_code changes.
REQ-011 Port gray_step_err SHALL be an output, 1 bit: sticky flag, set when a committed code differs from the previous code in more than one bit.

Function
REQ-012 Every raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 The four synchronized switch bits SHALL be debounced as one group through a candidate register and a counter; the counter SHALL clear whenever the synchronized value differs from the candidate.
REQ-014 Commit rule: when the counter reaches DEBOUNCE_CYCLES-1 with candidate != gray_code, gray_code SHALL load the candidate on the next edge and gray_valid SHALL pulse high for exactly that cycle.
REQ-015 Worst-case latency from a stable raw change to gray_code SHALL be 2 + DEBOUNCE_CYCLES cycles.
REQ-016 Any bounce shorter than DEBOUNCE_CYCLES SHALL leave gray_code, gray_valid and gray_step_err unchanged.
REQ-017 The counter SHALL saturate at DEBOUNCE_CYCLES-1 and SHALL NOT wrap while the input stays stable.
REQ-018 gray_step_err SHALL be set in the commit cycle when popcount(new XOR old) > 1, and SHALL clear only on reset.
REQ-019 The button SHALL use a four-state FSM.
 - IDLE -> PRESS_WAIT when sync btn = 1.
 - PRESS_WAIT -> HELD after DEBOUNCE_CYCLES consecutive cycles at 1; back to IDLE on any 0.
 - HELD -> RELEASE_WAIT when sync btn = 0.
 - RELEASE_WAIT -> IDLE after DEBOUNCE_CYCLES consecutive cycles at 0; back to HELD on any 1.
REQ-020 With BTN_TOGGLE=1, show_decades SHALL invert once on the PRESS_WAIT->HELD transition only.
REQ-021 With BTN_TOGGLE=0, show_decades SHALL be 1 in HELD and RELEASE_WAIT, and 0 otherwise.
REQ-022 The switch path and the button path SHALL be independent; simultaneous commits on both paths SHALL both take effect in the same cycle.
REQ-023 All outputs SHALL be driven directly from flops.

Reset
REQ-024 On rst = 1, all outputs, the synchronizers, candidates, counters and the FSM (IDLE) SHALL go to 0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-debounce SHALL discard the pending candidate; after release, a stable input SHALL need the full 2 + DEBOUNCE_CYCLES cycles to commit.
REQ-026 After reset, a switch value of 4'b0000 SHALL produce no gray_valid pulse, because it equals the reset gray_code.

Structure
REQ-027 Package gray_pkg SHALL hold:
 - the button FSM state typedef;
 - the default DEBOUNCE_CYCLES value;
 - the counter width function, ceil(log2(DEBOUNCE_CYCLES)).
REQ-028 Sub-module debounce_counter SHALL be parameterized by width and cycles.
 - Inputs: sample, stable_target.
 - Output: commit.
 - It SHALL be instantiated once for the switch group and reused by the button FSM for its count.
REQ-029 The 2-flop synchronizer SHALL be coded inline in this block, not as a separate module.

Verification (benches SHALL use DEBOUNCE_CYCLES=4)
REQ-030 Reset, then gray_raw = 4'b0011 held for 10 cycles -> gray_code = 4'b0011 exactly 6 cycles after the change, gray_valid pulses once, gray_step_err = 1 (two bits changed).
REQ-031 Reset, gray_raw toggles 0000 -> 0001 -> 0000 every 2 cycles for 20 cycles -> gray_code stays 0000 and gray_valid stays 0.
REQ-032 Gray sequence 0000 -> 0001 -> 0011 -> 0010, each held for 8 cycles -> three gray_valid pulses, and gray_step_err is 0 only if the first step came from reset.
REQ-033 BTN_TOGGLE=1: press held 6 cycles, release 6 cycles, repeated twice -> show_decades goes 0 -> 1 -> 0; a 2-cycle glitch in HELD causes no toggle.
REQ-034 rst pulsed while the switch counter is at 2 with a pending 4'b1000 -> gray_code = 0 immediately; after release, commit occurs only 6 cycles later.
REQ-035 Switch commit and button press completing in the same cycle -> gray_valid pulses and show_decades toggles on the same edge.
